spi_ram_arbiter: RTL and testbench
==================================

Name: spi_ram_arbiter

Overview:
Shares the single spi_ram_controller between two requesters: port 0 (CPU core) and port 1 (host/debug loader, e.g. a program-load or memory-inspect engine). Each port presents the same start/busy/data interface the controller exposes, so the CPU connects unchanged. The arbiter captures pulsed requests, grants round-robin, sequences one controller transaction at a time, and returns read data per port.

Parameters:
ADDR_BITS, 16, address width of ports and controller
DATA_BITS, 16, data word width (2 bytes for the controller)

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
p0_addr  input  ADDR_BITS  port 0 address, sampled with start
p0_data_in  input  DATA_BITS  port 0 write data, sampled with start
p0_start_read  input  1  port 0 read request pulse
p0_start_write  input  1  port 0 write request pulse
p0_data_out  output  DATA_BITS  port 0 last read data, registered
p0_busy  output  1  port 0 request pending or in flight
p1_addr, p1_data_in, p1_start_read, p1_start_write, p1_data_out, p1_busy  as port 0, for port 1
mem_addr  output  ADDR_BITS  to controller addr_in
mem_data_in  output  DATA_BITS  to controller data_in
mem_start_read  output  1  to controller start_read
mem_start_write  output  1  to controller start_write
mem_data_out  input  DATA_BITS  from controller data_out
mem_busy  input  1  from controller busy
grant  output  1  port owning current/last transaction
active  output  1  high in any state other than IDLE

Behaviour:
- Reset: clk, rst_n synchronous active-low. All outputs 0, pending flags clear, state IDLE, round-robin pointer favours port 0. Reset mid-transaction abandons it; controller shares rst_n.
- Request capture per port: start_read or start_write while that port's busy=0 latches addr, data_in, and is_write into a pending slot; pN_busy=1 from the next cycle. Both starts in one cycle: treated as write. Start while pN_busy=1: ignored, no state change.
- FSM: IDLE -> ISSUE -> WAIT_ACK -> WAIT_DONE -> IDLE.
- IDLE: if any slot pending, pick winner, set grant, drive mem_addr/mem_data_in from the slot, go ISSUE. Both pending: the port not served last wins, then pointer flips. Single pending: that port wins regardless of pointer.
- ISSUE: exactly one cycle of mem_start_read or mem_start_write per slot is_write; go WAIT_ACK.
- WAIT_ACK: wait for mem_busy=1, then WAIT_DONE.
- WAIT_DONE: on mem_busy=0, for a read load mem_data_out into pN_data_out, clear slot and pN_busy in the same edge, go IDLE.
- mem_addr/mem_data_in held stable from IDLE grant through WAIT_DONE; 0 when idle.
- pN_data_out changes only on completed reads of that port; writes leave it unchanged.
- Latency, uncontended: start at edge t; busy=1 at t+1; mem_start at t+2; busy falls the cycle after mem_busy falls. pN_busy is never low between start and completion, so the CPU's "wait for !busy" pattern holds.
- Requests arriving while the other port is in flight stay pending and are served next; no starvation under continuous requests from both ports.

Optional Feature:
ARB_HOST_LOCK_EN: adds input host_lock (1 bit). With the macro defined, while host_lock=1 IDLE never grants port 0; port 0 requests stay pending with p0_busy=1 and an in-flight port 0 transaction completes normally. When host_lock=0, port 0 pending is served under normal round-robin. Without the macro, the port is absent and arbitration is pure round-robin.

Test Plan:
- p0 read addr 0x0010, model returns 0x1234 -> single mem_start_read at t+2 with mem_addr=0x0010; p0_data_out=0x1234; p0_busy high t+1 until completion.
- p1 write 0xBEEF to 0x0200 -> one mem_start_write, mem_data_in=0xBEEF held until mem_busy falls; p1_data_out unchanged.
- Simultaneous p0 read 0x0004 and p1 read 0x0008 after reset -> port 0 served first, then port 1; grant 0 then 1; both data_out correct.
- Back-to-back continuous requests on both ports for 8 transactions -> grants strictly alternate 0,1,0,1...
- Start pulse on p0 while p0_busy=1 (addr 0x0FFF) -> ignored, no extra mem start; start_read+start_write together -> write issued.
- ARB_HOST_LOCK_EN: host_lock=1, p0 read pending, p1 writes x3 -> three port 1 transactions only; host_lock=0 -> p0 read served next. Also cover rst_n low during WAIT_DONE -> all outputs 0, IDLE next cycle.

Source files
------------

// File: rtl/spi_ram_arbiter_if.sv
// spi_ram_arbiter_if: start/busy/data handshake shared by requesters and the SPI RAM controller.
//   master: addr, data_in, start_read, start_write out; data_out, busy in (requester side)
//   slave : the reverse (memory/controller side)
interface spi_ram_arbiter_if #(
    parameter int ADDR_BITS = 16,
    parameter int DATA_BITS = 16
);
    logic [ADDR_BITS-1:0] addr;
    logic [DATA_BITS-1:0] data_in;
    logic                 start_read;
    logic                 start_write;
    logic [DATA_BITS-1:0] data_out;
    logic                 busy;
    modport master (output addr, data_in, start_read, start_write, input data_out, busy);
    modport slave  (input addr, data_in, start_read, start_write, output data_out, busy);
endinterface

// File: rtl/spi_ram_arbiter.sv
// spi_ram_arbiter: round-robin sharing of one spi_ram_controller between CPU (p0) and host loader (p1).
//   clk, rst_n      : clock, synchronous active-low reset
//   p0, p1          : requester ports (slave side of spi_ram_arbiter_if)
//   mem             : controller port (master side of spi_ram_arbiter_if)
//   grant           : port owning the current/last transaction
//   active          : FSM not idle
//   host_lock       : present only with ARB_HOST_LOCK_EN; blocks new grants to port 0
module spi_ram_arbiter #(
    parameter int ADDR_BITS = 16,
    parameter int DATA_BITS = 16
) (
    input  logic clk,
    input  logic rst_n,
`ifdef ARB_HOST_LOCK_EN
    input  logic host_lock,
`endif
    spi_ram_arbiter_if.slave  p0,
    spi_ram_arbiter_if.slave  p1,
    spi_ram_arbiter_if.master mem,
    output logic grant,
    output logic active
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE} state_t;
    state_t state, next;
    logic [1:0] start_rd, start_wr, pend, wr_q, elig;
    logic [ADDR_BITS-1:0] req_addr [2];
    logic [DATA_BITS-1:0] req_data [2];
    logic [ADDR_BITS-1:0] addr_q [2];
    logic [DATA_BITS-1:0] data_q [2];
    logic [DATA_BITS-1:0] dout [2];
    logic [ADDR_BITS-1:0] maddr;
    logic [DATA_BITS-1:0] mdata;
    logic prio, cur_wr, winner, done, lock;
`ifdef ARB_HOST_LOCK_EN
    assign lock = host_lock;
`else
    assign lock = 1'b0;
`endif
    assign start_rd    = {p1.start_read, p0.start_read};
    assign start_wr    = {p1.start_write, p0.start_write};
    assign req_addr[0] = p0.addr;
    assign req_addr[1] = p1.addr;
    assign req_data[0] = p0.data_in;
    assign req_data[1] = p1.data_in;
    assign elig   = {pend[1], pend[0] & ~lock};
    // prio names the port that did not win last; it only matters when both are eligible
    assign winner = (elig == 2'b11) ? prio : elig[1];
    assign done   = (state == WAIT_DONE) && !mem.busy;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend <= '0;
            wr_q <= '0;
            for (int i = 0; i < 2; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                // a set pending flag doubles as the port's busy, so starts while busy are dropped
                if (!pend[i] && (start_rd[i] || start_wr[i])) begin
                    pend[i]   <= 1'b1;
                    addr_q[i] <= req_addr[i];
                    data_q[i] <= req_data[i];
                    wr_q[i]   <= start_wr[i];
                end else if (done && grant == 1'(i)) begin
                    pend[i] <= 1'b0;
                end
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= next;
    end
    always_comb begin
        next = state;
        next = (state == IDLE)     ? (|elig ? ISSUE : IDLE) :
               (state == ISSUE)    ? WAIT_ACK :
               (state == WAIT_ACK) ? (mem.busy ? WAIT_DONE : WAIT_ACK) :
                                     (mem.busy ? WAIT_DONE : IDLE);
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant   <= 1'b0;
            prio    <= 1'b0;
            cur_wr  <= 1'b0;
            maddr   <= '0;
            mdata   <= '0;
            dout[0] <= '0;
            dout[1] <= '0;
        end else begin
            if (state == IDLE && |elig) begin
                grant  <= winner;
                prio   <= ~winner;
                cur_wr <= wr_q[winner];
                maddr  <= addr_q[winner];
                mdata  <= data_q[winner];
            end
            if (done) begin
                maddr <= '0;
                mdata <= '0;
                if (!cur_wr) dout[grant] <= mem.data_out;
            end
        end
    end
    assign mem.addr        = maddr;
    assign mem.data_in     = mdata;
    assign mem.start_read  = (state == ISSUE) && !cur_wr;
    assign mem.start_write = (state == ISSUE) && cur_wr;
    assign p0.busy         = pend[0];
    assign p1.busy         = pend[1];
    assign p0.data_out     = dout[0];
    assign p1.data_out     = dout[1];
    assign active          = (state != IDLE);
endmodule

// File: tb/tb_spi_ram_arbiter.sv
// tb_spi_ram_arbiter: scoreboard bench for spi_ram_arbiter with a behavioural SPI RAM controller.
module tb_spi_ram_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic grant, active;
    always #5 clk = ~clk;
    spi_ram_arbiter_if #(.ADDR_BITS(16), .DATA_BITS(16)) p0_if ();
    spi_ram_arbiter_if #(.ADDR_BITS(16), .DATA_BITS(16)) p1_if ();
    spi_ram_arbiter_if #(.ADDR_BITS(16), .DATA_BITS(16)) mem_if ();
`ifdef ARB_HOST_LOCK_EN
    logic host_lock = 1'b0;
`endif
    spi_ram_arbiter #(.ADDR_BITS(16), .DATA_BITS(16)) dut (
        .clk(clk),
        .rst_n(rst_n),
`ifdef ARB_HOST_LOCK_EN
        .host_lock(host_lock),
`endif
        .p0(p0_if),
        .p1(p1_if),
        .mem(mem_if),
        .grant(grant),
        .active(active)
    );

    // behavioural controller: busy rises the edge after a start, stays up 4 cycles
    logic [15:0] mem_model [logic [15:0]];
    int cnt;
    logic [15:0] m_a, m_d;
    logic m_w;
    always @(posedge clk) begin
        if (!rst_n) begin
            mem_if.busy     <= 1'b0;
            mem_if.data_out <= 16'h0;
            cnt             <= 0;
        end else if (mem_if.start_read || mem_if.start_write) begin
            mem_if.busy <= 1'b1;
            cnt         <= 3;
            m_a         <= mem_if.addr;
            m_d         <= mem_if.data_in;
            m_w         <= mem_if.start_write;
        end else if (mem_if.busy) begin
            if (cnt == 0) begin
                mem_if.busy <= 1'b0;
                if (m_w) mem_model[m_a] = m_d;
                else mem_if.data_out <= mem_model.exists(m_a) ? mem_model[m_a] : 16'h0;
            end else begin
                cnt <= cnt - 1;
            end
        end
    end

    typedef struct {
        logic        port;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] data;
    } txn_t;
    txn_t sb[$];
    txn_t cur;
    int errors = 0;
    int checks = 0;
    int issues = 0;
    logic [15:0] hold_a, hold_d;
    logic holding = 1'b0;

    // scoreboard monitor: every controller start must match the next expected transaction
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_if.start_read || mem_if.start_write) begin
                issues++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL issue_unexpected: got grant=%0d wr=%b addr=%h, required no transaction", grant, mem_if.start_write, mem_if.addr);
                end else begin
                    cur = sb.pop_front();
                    if (grant !== cur.port || mem_if.start_write !== cur.wr || mem_if.start_read !== ~cur.wr ||
                        mem_if.addr !== cur.addr || (cur.wr && mem_if.data_in !== cur.data)) begin
                        errors++;
                        $display("FAIL issue: got grant=%0d wr=%b rd=%b addr=%h data=%h, required grant=%0d wr=%b addr=%h data=%h",
                                 grant, mem_if.start_write, mem_if.start_read, mem_if.addr, mem_if.data_in,
                                 cur.port, cur.wr, cur.addr, cur.data);
                    end
                end
                hold_a  = mem_if.addr;
                hold_d  = mem_if.data_in;
                holding = 1'b1;
            end else if (holding && active) begin
                checks++;
                if (mem_if.addr !== hold_a || mem_if.data_in !== hold_d) begin
                    errors++;
                    $display("FAIL hold: got addr=%h data=%h, required addr=%h data=%h", mem_if.addr, mem_if.data_in, hold_a, hold_d);
                end
            end else begin
                holding = 1'b0;
            end
        end
    end

    task automatic wait_idle(output bit ok);
        int n = 0;
        while ((p0_if.busy || p1_if.busy || active) && n < 300) begin
            @(negedge clk);
            n++;
        end
        ok = !(p0_if.busy || p1_if.busy || active);
    endtask

    task automatic pulse(input bit port, input bit rd, input bit wr, input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        if (port) begin
            p1_if.addr = a; p1_if.data_in = d; p1_if.start_read = rd; p1_if.start_write = wr;
        end else begin
            p0_if.addr = a; p0_if.data_in = d; p0_if.start_read = rd; p0_if.start_write = wr;
        end
        @(negedge clk);
        p0_if.start_read = 0; p0_if.start_write = 0; p1_if.start_read = 0; p1_if.start_write = 0;
        p0_if.addr = 0; p0_if.data_in = 0; p1_if.addr = 0; p1_if.data_in = 0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({p0_if.busy, p1_if.busy, p0_if.data_out, p1_if.data_out, mem_if.addr, mem_if.data_in,
             mem_if.start_read, mem_if.start_write, grant, active} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got p0b=%b p1b=%b d0=%h d1=%h ma=%h md=%h sr=%b sw=%b g=%b act=%b, required all 0",
                     p0_if.busy, p1_if.busy, p0_if.data_out, p1_if.data_out, mem_if.addr, mem_if.data_in,
                     mem_if.start_read, mem_if.start_write, grant, active);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (active !== 1'b0 || p0_if.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got active=%b p0_busy=%b, required 0 0", active, p0_if.busy);
        end
    endtask

    task automatic test_read_p0;
        int n = 0;
        int base = issues;
        logic prev = 1'b0, prev2 = 1'b0;
        mem_model[16'h0010] = 16'h1234;
        sb.push_back('{1'b0, 1'b0, 16'h0010, 16'h0000});
        @(negedge clk);
        p0_if.addr = 16'h0010; p0_if.start_read = 1'b1;
        @(negedge clk);
        p0_if.start_read = 1'b0; p0_if.addr = 16'h0;
        checks++;
        if (p0_if.busy !== 1'b1 || mem_if.start_read !== 1'b0) begin
            errors++;
            $display("FAIL read_t1: got busy=%b start=%b, required busy=1 start=0", p0_if.busy, mem_if.start_read);
        end
        @(negedge clk);
        checks++;
        if (mem_if.start_read !== 1'b1 || mem_if.addr !== 16'h0010) begin
            errors++;
            $display("FAIL read_t2: got start=%b addr=%h, required start=1 addr=0010", mem_if.start_read, mem_if.addr);
        end
        while (p0_if.busy && n < 100) begin
            prev2 = prev;
            prev = mem_if.busy;
            @(negedge clk);
            n++;
        end
        checks++;
        if (p0_if.busy !== 1'b0 || prev !== 1'b0 || prev2 !== 1'b1) begin
            errors++;
            $display("FAIL read_busy_fall: got busy=%b mem_busy[-1]=%b mem_busy[-2]=%b, required 0 0 1", p0_if.busy, prev, prev2);
        end
        checks++;
        if (p0_if.data_out !== 16'h1234 || issues - base != 1) begin
            errors++;
            $display("FAIL read_data: got data=%h issues=%0d, required data=1234 issues=1", p0_if.data_out, issues - base);
        end
    endtask

    task automatic test_write_p1;
        bit ok;
        sb.push_back('{1'b1, 1'b1, 16'h0200, 16'hBEEF});
        pulse(1'b1, 1'b0, 1'b1, 16'h0200, 16'hBEEF);
        wait_idle(ok);
        checks++;
        if (!ok || p1_if.data_out !== 16'h0000 || !mem_model.exists(16'h0200) || mem_model[16'h0200] !== 16'hBEEF) begin
            errors++;
            $display("FAIL write_p1: got idle=%b p1_data=%h, required idle=1 p1_data=0000 and mem[0200]=beef", ok, p1_if.data_out);
        end
    endtask

    task automatic test_simultaneous;
        bit ok;
        test_reset();
        mem_model[16'h0004] = 16'hA004;
        mem_model[16'h0008] = 16'hB008;
        sb.push_back('{1'b0, 1'b0, 16'h0004, 16'h0000});
        sb.push_back('{1'b1, 1'b0, 16'h0008, 16'h0000});
        @(negedge clk);
        p0_if.addr = 16'h0004; p0_if.start_read = 1'b1;
        p1_if.addr = 16'h0008; p1_if.start_read = 1'b1;
        @(negedge clk);
        p0_if.start_read = 1'b0; p1_if.start_read = 1'b0;
        wait_idle(ok);
        checks++;
        if (!ok || p0_if.data_out !== 16'hA004 || p1_if.data_out !== 16'hB008 || grant !== 1'b1 || sb.size() != 0) begin
            errors++;
            $display("FAIL simultaneous: got idle=%b d0=%h d1=%h grant=%b left=%0d, required 1 a004 b008 1 0",
                     ok, p0_if.data_out, p1_if.data_out, grant, sb.size());
        end
    endtask

    task automatic test_back_to_back;
        int k0 = 0, k1 = 0, n = 0;
        int base = issues;
        for (int k = 0; k < 4; k++) begin
            sb.push_back('{1'b0, 1'b1, 16'h0100 + 16'(k), 16'h1000 + 16'(k)});
            sb.push_back('{1'b1, 1'b1, 16'h0180 + 16'(k), 16'h2000 + 16'(k)});
        end
        while ((k0 < 4 || k1 < 4 || p0_if.busy || p1_if.busy || active) && n < 600) begin
            @(negedge clk);
            n++;
            if (!p0_if.busy && k0 < 4) begin
                p0_if.start_write = 1'b1; p0_if.addr = 16'h0100 + 16'(k0); p0_if.data_in = 16'h1000 + 16'(k0); k0++;
            end else p0_if.start_write = 1'b0;
            if (!p1_if.busy && k1 < 4) begin
                p1_if.start_write = 1'b1; p1_if.addr = 16'h0180 + 16'(k1); p1_if.data_in = 16'h2000 + 16'(k1); k1++;
            end else p1_if.start_write = 1'b0;
        end
        p0_if.start_write = 1'b0; p1_if.start_write = 1'b0;
        checks++;
        if (issues - base != 8 || sb.size() != 0 || active !== 1'b0) begin
            errors++;
            $display("FAIL back_to_back: got issues=%0d left=%0d active=%b, required 8 0 0", issues - base, sb.size(), active);
        end
    endtask

    task automatic test_ignore_and_both;
        bit ok;
        int base = issues;
        mem_model[16'h0020] = 16'h7777;
        sb.push_back('{1'b0, 1'b0, 16'h0020, 16'h0000});
        pulse(1'b0, 1'b1, 1'b0, 16'h0020, 16'h0000);
        pulse(1'b0, 1'b1, 1'b0, 16'h0FFF, 16'h0000);
        wait_idle(ok);
        checks++;
        if (!ok || p0_if.data_out !== 16'h7777 || issues - base != 1) begin
            errors++;
            $display("FAIL ignore_busy_start: got idle=%b d0=%h issues=%0d, required 1 7777 1", ok, p0_if.data_out, issues - base);
        end
        sb.push_back('{1'b0, 1'b1, 16'h0030, 16'h5A5A});
        pulse(1'b0, 1'b1, 1'b1, 16'h0030, 16'h5A5A);
        wait_idle(ok);
        checks++;
        if (!ok || p0_if.data_out !== 16'h7777 || !mem_model.exists(16'h0030) || mem_model[16'h0030] !== 16'h5A5A) begin
            errors++;
            $display("FAIL both_starts_write: got idle=%b d0=%h, required idle=1 d0=7777 and mem[0030]=5a5a", ok, p0_if.data_out);
        end
    endtask

    task automatic test_reset_mid;
        int n = 0;
        sb.push_back('{1'b1, 1'b0, 16'h0010, 16'h0000});
        pulse(1'b1, 1'b1, 1'b0, 16'h0010, 16'h0000);
        while (!mem_if.busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        checks++;
        if (mem_if.busy !== 1'b1 || active !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_setup: got mem_busy=%b active=%b, required 1 1", mem_if.busy, active);
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({p0_if.busy, p1_if.busy, p0_if.data_out, p1_if.data_out, mem_if.addr, mem_if.data_in,
             mem_if.start_read, mem_if.start_write, grant, active} !== '0) begin
            errors++;
            $display("FAIL reset_mid: got p1b=%b d0=%h ma=%h g=%b act=%b, required all 0", p1_if.busy, p0_if.data_out, mem_if.addr, grant, active);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (active !== 1'b0 || p1_if.busy !== 1'b0 || sb.size() != 0) begin
            errors++;
            $display("FAIL reset_mid_after: got active=%b p1_busy=%b left=%0d, required 0 0 0", active, p1_if.busy, sb.size());
        end
    endtask

`ifdef ARB_HOST_LOCK_EN
    task automatic test_host_lock;
        bit ok;
        int n;
        int base = issues;
        host_lock = 1'b1;
        for (int k = 0; k < 3; k++) sb.push_back('{1'b1, 1'b1, 16'h0300 + 16'(k), 16'hC000 + 16'(k)});
        sb.push_back('{1'b0, 1'b0, 16'h0020, 16'h0000});
        pulse(1'b0, 1'b1, 1'b0, 16'h0020, 16'h0000);
        for (int k = 0; k < 3; k++) begin
            pulse(1'b1, 1'b0, 1'b1, 16'h0300 + 16'(k), 16'hC000 + 16'(k));
            n = 0;
            while ((p1_if.busy || active) && n < 100) begin
                @(negedge clk);
                n++;
            end
        end
        repeat (3) @(negedge clk);
        checks++;
        if (p0_if.busy !== 1'b1 || issues - base != 3) begin
            errors++;
            $display("FAIL host_lock_hold: got p0_busy=%b issues=%0d, required 1 3", p0_if.busy, issues - base);
        end
        host_lock = 1'b0;
        wait_idle(ok);
        checks++;
        if (!ok || p0_if.data_out !== 16'h7777 || sb.size() != 0) begin
            errors++;
            $display("FAIL host_lock_release: got idle=%b d0=%h left=%0d, required 1 7777 0", ok, p0_if.data_out, sb.size());
        end
    endtask
`endif

    initial begin
        p0_if.addr = 0; p0_if.data_in = 0; p0_if.start_read = 0; p0_if.start_write = 0;
        p1_if.addr = 0; p1_if.data_in = 0; p1_if.start_read = 0; p1_if.start_write = 0;
        test_reset();
        test_read_p0();
        test_write_p1();
        test_simultaneous();
        test_back_to_back();
        test_ignore_and_both();
        test_reset_mid();
`ifdef ARB_HOST_LOCK_EN
        test_host_lock();
`endif
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
